// File: rtl/regfile_sb.sv
// Multi-port register file with a busy-bit scoreboard for long-latency writeback.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD-1:0]        rd_en_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     we0_i,
    input  logic [ADDR_W-1:0]        waddr0_i,
    input  logic [DATA_W-1:0]        wdata0_i,
    input  logic                     we1_i,
    input  logic [ADDR_W-1:0]        waddr1_i,
    input  logic [DATA_W-1:0]        wdata1_i,
    input  logic                     res_en_i,
    input  logic [ADDR_W-1:0]        res_addr_i,
    output logic [ADDR_W:0]          busy_cnt_o,
    output logic                     wr_collide_o,
    output logic                     res_err_o
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
    logic              wr_collide_q, wr_collide_d;
    logic              res_err_q, res_err_d;
    logic              wr0_ok, wr1_ok, res_ok, same_rel;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return !(ZERO_REG != 0 && a == '0);
    endfunction

    always_comb begin
        wr0_ok   = we0_i && addr_ok(waddr0_i);
        wr1_ok   = we1_i && addr_ok(waddr1_i);
        res_ok   = res_en_i && addr_ok(res_addr_i);
        same_rel = we1_i && (waddr1_i == res_addr_i);

        // Reserve is applied after release so it wins on a shared address.
        busy_d = busy_q;
        if (we1_i)  busy_d[waddr1_i]   = 1'b0;
        if (res_ok) busy_d[res_addr_i] = 1'b1;

        busy_cnt_d = busy_cnt_q;
        if (res_ok && !busy_q[res_addr_i])
            busy_cnt_d = busy_cnt_d + CNT_ONE;
        if (we1_i && busy_q[waddr1_i] && !(res_ok && waddr1_i == res_addr_i))
            busy_cnt_d = busy_cnt_d - CNT_ONE;

        wr_collide_d = we0_i && we1_i && (waddr0_i == waddr1_i);
        res_err_d    = res_ok && busy_q[res_addr_i] && !same_rel;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            // Port 0 is written last so it takes precedence on a collision.
            if (wr1_ok) mem_q[waddr1_i] <= wdata1_i;
            if (wr0_ok) mem_q[waddr0_i] <= wdata0_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q       <= '0;
            busy_cnt_q   <= '0;
            wr_collide_q <= 1'b0;
            res_err_q    <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            busy_cnt_q   <= busy_cnt_d;
            wr_collide_q <= wr_collide_d;
            res_err_q    <= res_err_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] data;
        logic              busy;

        always_comb begin
            ra   = rd_addr_i[k*ADDR_W +: ADDR_W];
            data = mem_q[ra];
            busy = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr0_ok && waddr0_i == ra)
                data = wdata0_i;
            else if (wr1_ok && waddr1_i == ra)
                data = wdata1_i;
            if (we1_i && waddr1_i == ra)
                busy = 1'b0;
`endif
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = rd_en_i[k] ? data : '0;
        assign rd_busy_o[k]                  = rd_en_i[k] & busy;
    end

    assign busy_cnt_o   = busy_cnt_q;
    assign wr_collide_o = wr_collide_q;
    assign res_err_o    = res_err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: array/scoreboard model plus directed vectors.
// Build with or without REGFILE_BYPASS_EN; the model follows the same define.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we0, we1, res_en;
    logic [4:0]  wa0, wa1, res_addr;
    logic [31:0] wd0, wd1;
    logic [5:0]  busy_cnt;
    logic        wr_collide, res_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk_i(clk), .rst_i(rst),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
        .we0_i(we0), .waddr0_i(wa0), .wdata0_i(wd0),
        .we1_i(we1), .waddr1_i(wa1), .wdata1_i(wd1),
        .res_en_i(res_en), .res_addr_i(res_addr),
        .busy_cnt_o(busy_cnt), .wr_collide_o(wr_collide), .res_err_o(res_err)
    );

    // Behavioural model: plain arrays, busy count is a population count.
    logic [31:0] m_mem [32];
    logic        m_busy [32];
    logic        m_col, m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  <= '0;
                m_busy[i] <= 1'b0;
            end
            m_col <= 1'b0;
            m_err <= 1'b0;
        end else begin
            m_col <= we0 && we1 && (wa0 == wa1);
            m_err <= res_en && res_addr != 0 && m_busy[res_addr] && !(we1 && wa1 == res_addr);
            if (we1 && wa1 != 0) m_mem[wa1] <= wd1;
            if (we0 && wa0 != 0) m_mem[wa0] <= wd0;
            if (we1) m_busy[wa1] <= 1'b0;
            if (res_en && res_addr != 0) m_busy[res_addr] <= 1'b1;
        end
    end

    function automatic logic [31:0] exp_data(int k);
        logic [4:0]  a;
        logic [31:0] d;
        a = rd_addr[k*5 +: 5];
        if (!rd_en[k]) return '0;
        d = m_mem[a];
`ifdef REGFILE_BYPASS_EN
        if (we0 && wa0 == a && a != 0) d = wd0;
        else if (we1 && wa1 == a && a != 0) d = wd1;
`endif
        return d;
    endfunction

    function automatic logic exp_busy(int k);
        logic [4:0] a;
        a = rd_addr[k*5 +: 5];
        if (!rd_en[k]) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (we1 && wa1 == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic logic [5:0] exp_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return 6'(c);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("rd_data0", {32'h0, rd_data[31:0]},  {32'h0, exp_data(0)});
            chk("rd_data1", {32'h0, rd_data[63:32]}, {32'h0, exp_data(1)});
            chk("rd_busy0", {63'h0, rd_busy[0]}, {63'h0, exp_busy(0)});
            chk("rd_busy1", {63'h0, rd_busy[1]}, {63'h0, exp_busy(1)});
            chk("busy_cnt", {58'h0, busy_cnt}, {58'h0, exp_cnt()});
            chk("wr_collide", {63'h0, wr_collide}, {63'h0, m_col});
            chk("res_err", {63'h0, res_err}, {63'h0, m_err});
        end
    end

    task automatic idle();
        we0 = 0; we1 = 0; res_en = 0;
        wa0 = '0; wa1 = '0; res_addr = '0; wd0 = '0; wd1 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] raddr(int a1, int a0);
        return {5'(a1), 5'(a0)};
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        rd_en = 2'b11;
        rd_addr = raddr(5, 5);
        #3;
        chk("reset rd_data", rd_data, 64'h0);
        chk("reset busy_cnt", {58'h0, busy_cnt}, 64'h0);
        tick();
        rst = 1'b0;
        tick();

        // Plain write then dual-port read.
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF;
        tick(); idle();
        chk("read p0/p1 reg5", rd_data, 64'hDEADBEEF_DEADBEEF);

        // Register 0 ignores writes.
        rd_addr = raddr(5, 0);
        we0 = 1; wa0 = 0; wd0 = 32'h1234;
        tick(); idle();
        chk("reg0 stays 0", {32'h0, rd_data[31:0]}, 64'h0);

        // Reserve then release via port 1.
        rd_addr = raddr(5, 8);
        res_en = 1; res_addr = 8;
        tick(); idle();
        chk("reg8 busy", {63'h0, rd_busy[0]}, 64'h1);
        chk("cnt after reserve", {58'h0, busy_cnt}, 64'h1);
        we1 = 1; wa1 = 8; wd1 = 32'hCAFE0001;
        tick(); idle();
        chk("reg8 released", {63'h0, rd_busy[0]}, 64'h0);
        chk("reg8 data", {32'h0, rd_data[31:0]}, 64'hCAFE0001);
        chk("cnt after release", {58'h0, busy_cnt}, 64'h0);

        // Reserve-and-release same address, then double reserve.
        rd_addr = raddr(5, 9);
        res_en = 1; res_addr = 9;
        tick(); idle();
        res_en = 1; res_addr = 9; we1 = 1; wa1 = 9; wd1 = 32'h99;
        tick(); idle();
        chk("reg9 still busy", {63'h0, rd_busy[0]}, 64'h1);
        chk("cnt reserve+release", {58'h0, busy_cnt}, 64'h1);
        chk("no res_err", {63'h0, res_err}, 64'h0);
        res_en = 1; res_addr = 9;
        tick(); idle();
        chk("res_err pulse", {63'h0, res_err}, 64'h1);
        chk("cnt after dup reserve", {58'h0, busy_cnt}, 64'h1);
        tick();
        chk("res_err cleared", {63'h0, res_err}, 64'h0);

        // Write collision: port 0 wins.
        rd_addr = raddr(3, 9);
        we0 = 1; wa0 = 3; wd0 = 32'hAAAA0000;
        we1 = 1; wa1 = 3; wd1 = 32'h5555FFFF;
        tick(); idle();
        chk("collide data", {32'h0, rd_data[63:32]}, 64'hAAAA0000);
        chk("wr_collide pulse", {63'h0, wr_collide}, 64'h1);
        tick();
        chk("wr_collide cleared", {63'h0, wr_collide}, 64'h0);

        // Same-cycle read of a register being written.
        rd_addr = raddr(3, 7);
        we0 = 1; wa0 = 7; wd0 = 32'h42;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass data", {32'h0, rd_data[31:0]}, 64'h42);
`else
        chk("no-bypass data", {32'h0, rd_data[31:0]}, 64'h0);
`endif
        tick(); idle();
        chk("reg7 written", {32'h0, rd_data[31:0]}, 64'h42);

        // Same-cycle release of a busy register on a read port.
        rd_addr = raddr(10, 7);
        res_en = 1; res_addr = 10;
        tick(); idle();
        we1 = 1; wa1 = 10; wd1 = 32'h77;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass busy", {63'h0, rd_busy[1]}, 64'h0);
`else
        chk("no-bypass busy", {63'h0, rd_busy[1]}, 64'h1);
`endif
        tick(); idle();
        chk("reg10 released", {63'h0, rd_busy[1]}, 64'h0);
        chk("cnt reg9 only", {58'h0, busy_cnt}, 64'h1);

        // Mixed directed traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 40; i++) begin
            we0 = (i % 3 == 0);  wa0 = 5'((i * 7 + 1) % 32);  wd0 = 32'h1000_0000 + 32'(i);
            we1 = (i % 4 == 1);  wa1 = 5'((i * 5 + 2) % 32);  wd1 = 32'hB000_0000 ^ 32'(i);
            res_en = (i % 3 == 1); res_addr = 5'((i * 11 + 3) % 32);
            rd_addr = raddr((i * 3) % 32, (i * 13 + 2) % 32);
            rd_en = (i % 5 == 4) ? 2'b01 : 2'b11;
            tick();
        end
        idle();
        rd_en = 2'b11;

        // Asynchronous reset in mid-cycle with state present.
        we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF;
        res_en = 1; res_addr = 20;
        tick(); idle();
        rd_addr = raddr(20, 5);
        chk("pre-reset busy", {63'h0, rd_busy[1]}, 64'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst rd_data", rd_data, 64'h0);
        chk("async rst rd_busy", {62'h0, rd_busy}, 64'h0);
        chk("async rst busy_cnt", {58'h0, busy_cnt}, 64'h0);
        rst = 1'b0;
        tick();
        chk("post-reset reg5", {32'h0, rd_data[31:0]}, 64'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
